// File: rtl/sprite_engine_multi.sv
// rtl/sprite_engine_multi.sv - multi-object sprite engine: hblank OAM scan, per-pixel priority, sprite ROM addressing
// Optional feature macro: SPRITE_ENGINE_ROTATE_EN (rotate ROM row/column offsets by dir, dir field forced to 00)
module sprite_engine_multi #(
  parameter int          NUM_OBJ      = 8,
  parameter int          MAX_PER_LINE = 4,
  parameter int          SPRITE_W     = 32,
  parameter int          EVAL_X       = 640,
  parameter int          V_LAST       = 524,
  parameter logic [11:0] TRANSPARENT  = 12'h000,
  localparam int         IW           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [IW-1:0] oam_addr,
  input  logic [31:0]   oam_data,
  output logic [17:0]   rom_addr,
  input  logic [11:0]   rom_data,
  output logic          sprite_on,
  output logic [11:0]   color,
  output logic [IW-1:0] obj_id,
  output logic          overflow,
  output logic          eval_busy
);

  localparam int          SW        = $clog2(MAX_PER_LINE + 1);
  localparam logic [SW-1:0] MAX_C   = SW'(MAX_PER_LINE);
  localparam logic [9:0]  W_C       = 10'(SPRITE_W);
  localparam logic [9:0]  EVAL_X_C  = 10'(EVAL_X);
  localparam logic [9:0]  V_LAST_C  = 10'(V_LAST);
  localparam logic [IW-1:0] LAST_ADDR = IW'(NUM_OBJ - 1);
`ifdef SPRITE_ENGINE_ROTATE_EN
  localparam logic [4:0]  WM1       = 5'(SPRITE_W - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_e;

  state_e state_q, state_d;
  logic   trig;
  logic   addr_inc;

  // OAM scan bookkeeping
  logic [IW-1:0] oam_addr_q;
  logic [IW-1:0] prev_addr_q;
  logic          prev_vld_q;
  logic [9:0]    target_q;
  logic [SW-1:0] fill_q;
  logic          overflow_q;

  // Per-line object slots
  logic [MAX_PER_LINE-1:0] slot_vld_q;
  logic [9:0]    slot_px_q   [MAX_PER_LINE];
  logic [4:0]    slot_row_q  [MAX_PER_LINE];
  logic [1:0]    slot_dir_q  [MAX_PER_LINE];
  logic [2:0]    slot_srow_q [MAX_PER_LINE];
  logic [2:0]    slot_scol_q [MAX_PER_LINE];
  logic [IW-1:0] slot_idx_q  [MAX_PER_LINE];

  // OAM entry decode
  logic [9:0] oam_dy;
  logic       obj_hit;
  logic       unused_oam_bits;

  assign oam_dy          = target_q - oam_data[17:8];
  assign obj_hit         = prev_vld_q & oam_data[28] & (oam_dy < W_C);
  assign unused_oam_bits = ^oam_data[31:29];

  // Evaluation state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: trigger only from IDLE, so a trigger while busy is ignored
  always_comb begin
    state_d  = state_q;
    trig     = 1'b0;
    addr_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!video_on && (x == EVAL_X_C)) begin
          state_d = S_SCAN;
          trig    = 1'b1;
        end
      end
      S_SCAN: begin
        if (oam_addr_q == LAST_ADDR) state_d = S_DRAIN;
        else                         addr_inc = 1'b1;
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan address, returned-data tracking, slot fill and overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oam_addr_q  <= '0;
      prev_addr_q <= '0;
      prev_vld_q  <= 1'b0;
      target_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      slot_vld_q  <= '0;
    end else begin
      // OAM data arriving next cycle belongs to the address presented now
      prev_addr_q <= oam_addr_q;
      prev_vld_q  <= (state_q == S_SCAN);
      if (trig) begin
        oam_addr_q <= '0;
        target_q   <= (y == V_LAST_C) ? 10'd0 : y + 10'd1;
        fill_q     <= '0;
        overflow_q <= 1'b0;
        slot_vld_q <= '0;
      end else begin
        if (addr_inc) oam_addr_q <= oam_addr_q + 1'b1;
        if (obj_hit) begin
          if (fill_q < MAX_C) begin
            for (int s = 0; s < MAX_PER_LINE; s++) begin
              if (fill_q == SW'(s)) slot_vld_q[s] <= 1'b1;
            end
            fill_q <= fill_q + 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end
      end
    end
  end

  // Slot payload capture; qualified by slot_vld_q so no reset is needed
  always_ff @(posedge clk) begin
    if (!trig && obj_hit && (fill_q < MAX_C)) begin
      for (int s = 0; s < MAX_PER_LINE; s++) begin
        if (fill_q == SW'(s)) begin
          slot_px_q[s]   <= oam_data[27:18];
          slot_row_q[s]  <= oam_dy[4:0];
          slot_dir_q[s]  <= oam_data[7:6];
          slot_srow_q[s] <= oam_data[5:3];
          slot_scol_q[s] <= oam_data[2:0];
          slot_idx_q[s]  <= prev_addr_q;
        end
      end
    end
  end

  // Stage 1 combinational: lowest-index hitting slot wins
  logic          pix_win;
  logic [4:0]    win_row;
  logic [4:0]    win_col;
  logic [1:0]    win_dir;
  logic [2:0]    win_srow;
  logic [2:0]    win_scol;
  logic [IW-1:0] win_idx;

  always_comb begin
    logic [9:0] dx;
    pix_win  = 1'b0;
    win_row  = '0;
    win_col  = '0;
    win_dir  = '0;
    win_srow = '0;
    win_scol = '0;
    win_idx  = '0;
    dx       = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      dx = x - slot_px_q[s];
      if (slot_vld_q[s] && (dx < W_C)) begin
        pix_win  = 1'b1;
        win_row  = slot_row_q[s];
        win_col  = dx[4:0];
        win_dir  = slot_dir_q[s];
        win_srow = slot_srow_q[s];
        win_scol = slot_scol_q[s];
        win_idx  = slot_idx_q[s];
      end
    end
  end

  // Offset mapping into the ROM address
  logic [4:0] rom_r;
  logic [4:0] rom_c;
  logic [1:0] rom_dir;

  always_comb begin
    rom_r   = win_row;
    rom_c   = win_col;
    rom_dir = win_dir;
`ifdef SPRITE_ENGINE_ROTATE_EN
    rom_dir = 2'b00;
    case (win_dir)
      2'd0: begin rom_r = win_row;       rom_c = win_col;       end
      2'd1: begin rom_r = win_col;       rom_c = WM1 - win_row; end
      2'd2: begin rom_r = WM1 - win_row; rom_c = WM1 - win_col; end
      default: begin rom_r = WM1 - win_col; rom_c = win_row;   end
    endcase
`endif
  end

  // Pixel pipeline: stage 1 address, stage 2 ROM wait, stage 3 output
  logic          win1_q, vid1_q, win2_q, vid2_q;
  logic [IW-1:0] id1_q, id2_q;
  logic [17:0]   rom_addr_q;
  logic          sprite_on_q;
  logic [11:0]   color_q;
  logic [IW-1:0] obj_id_q;
  logic          show;

  assign show = vid2_q & win2_q & (rom_data != TRANSPARENT);

  // Pixel pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q  <= '0;
      win1_q      <= 1'b0;
      vid1_q      <= 1'b0;
      id1_q       <= '0;
      win2_q      <= 1'b0;
      vid2_q      <= 1'b0;
      id2_q       <= '0;
      sprite_on_q <= 1'b0;
      color_q     <= '0;
      obj_id_q    <= '0;
    end else begin
      rom_addr_q  <= {win_srow, win_scol, rom_dir, rom_r, rom_c};
      win1_q      <= pix_win;
      vid1_q      <= video_on;
      id1_q       <= win_idx;
      win2_q      <= win1_q;
      vid2_q      <= vid1_q;
      id2_q       <= id1_q;
      sprite_on_q <= show;
      color_q     <= show ? rom_data : 12'h000;
      obj_id_q    <= show ? id2_q : '0;
    end
  end

  assign oam_addr  = oam_addr_q;
  assign rom_addr  = rom_addr_q;
  assign sprite_on = sprite_on_q;
  assign color     = color_q;
  assign obj_id    = obj_id_q;
  assign overflow  = overflow_q;
  assign eval_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_engine_multi.sv
// tb/tb_sprite_engine_multi.sv - scoreboard bench for sprite_engine_multi
module tb_sprite_engine_multi;

  localparam int NOBJ = 8;
  localparam int MAXS = 4;
  localparam int W    = 32;
  localparam int EVX  = 640;
  localparam int VL   = 524;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        video_on;
  logic [9:0]  x, y;
  logic [2:0]  oam_addr;
  logic [31:0] oam_data;
  logic [17:0] rom_addr;
  logic [11:0] rom_data;
  logic        sprite_on;
  logic [11:0] color;
  logic [2:0]  obj_id;
  logic        overflow;
  logic        eval_busy;

  always #5 clk = ~clk;

  sprite_engine_multi dut (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y),
    .oam_addr(oam_addr), .oam_data(oam_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .sprite_on(sprite_on), .color(color), .obj_id(obj_id),
    .overflow(overflow), .eval_busy(eval_busy)
  );

  // External memories: one-cycle registered reads
  logic [31:0] oam_mem [NOBJ];

  function automatic logic [11:0] rom_fn(input logic [17:0] a);
    if (a[17:15] == 3'd7) return 12'h000;
    return (a[11:0] ^ {a[17:12], a[17:12]}) | 12'h001;
  endfunction

  always @(posedge clk) oam_data <= oam_mem[oam_addr];
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  function automatic logic [31:0] oam_word(input logic en, input int px, input int py,
                                           input logic [1:0] dir, input logic [2:0] sr, input logic [2:0] sc);
    return {3'b101, en, 10'(px), 10'(py), dir, sr, sc};
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the selected slots
  logic [9:0] m_px   [MAXS];
  logic [4:0] m_row  [MAXS];
  logic [1:0] m_dir  [MAXS];
  logic [2:0] m_srow [MAXS];
  logic [2:0] m_scol [MAXS];
  logic [2:0] m_idx  [MAXS];
  int         m_cnt = 0;
  bit         m_ovf = 0;

  function automatic void model_eval(input logic [9:0] ey);
    logic [9:0]  tgt, dy;
    logic [31:0] w;
    tgt   = (ey == 10'(VL)) ? 10'd0 : ey + 10'd1;
    m_cnt = 0;
    m_ovf = 0;
    for (int i = 0; i < NOBJ; i++) begin
      w  = oam_mem[i];
      dy = tgt - w[17:8];
      if (w[28] && dy < 10'(W)) begin
        if (m_cnt < MAXS) begin
          m_px[m_cnt]   = w[27:18];
          m_row[m_cnt]  = dy[4:0];
          m_dir[m_cnt]  = w[7:6];
          m_srow[m_cnt] = w[5:3];
          m_scol[m_cnt] = w[2:0];
          m_idx[m_cnt]  = 3'(i);
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endfunction

  typedef struct {
    logic        on;
    logic [11:0] col;
    logic [2:0]  id;
    int          px;
    int          py;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t model_pixel(input logic [9:0] xv, input logic [9:0] yv, input logic vv);
    exp_t        e;
    logic [9:0]  dx;
    logic [4:0]  r, c, wm;
    logic [17:0] a;
    logic [11:0] col;
    bit          found;
    e.on = 0; e.col = '0; e.id = '0; e.px = int'(xv); e.py = int'(yv);
    found = 0;
    wm = 5'(W - 1);
    if (vv) begin
      for (int s = 0; s < m_cnt; s++) begin
        dx = xv - m_px[s];
        if (!found && dx < 10'(W)) begin
          found = 1;
          r = m_row[s];
          c = dx[4:0];
`ifdef SPRITE_ENGINE_ROTATE_EN
          case (m_dir[s])
            2'd0: a = {m_srow[s], m_scol[s], 2'b00, r, c};
            2'd1: a = {m_srow[s], m_scol[s], 2'b00, c, wm - r};
            2'd2: a = {m_srow[s], m_scol[s], 2'b00, wm - r, wm - c};
            default: a = {m_srow[s], m_scol[s], 2'b00, wm - c, r};
          endcase
`else
          a = {m_srow[s], m_scol[s], m_dir[s], r, c};
`endif
          col = rom_fn(a);
          if (col != 12'h000) begin
            e.on = 1; e.col = col; e.id = m_idx[s];
          end
        end
      end
    end
    return e;
  endfunction

  // One pixel clock: retire the entry whose output is due, then drive and predict the next
  task automatic step(input logic [9:0] xv, input logic [9:0] yv, input logic vv);
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 3) begin
      e = sbq.pop_front();
      check_eq($sformatf("sprite_on@x%0d,y%0d", e.px, e.py), 32'(sprite_on), 32'(e.on));
      check_eq($sformatf("color@x%0d,y%0d", e.px, e.py), 32'(color), 32'(e.col));
      check_eq($sformatf("obj_id@x%0d,y%0d", e.px, e.py), 32'(obj_id), 32'(e.id));
    end
    x = xv; y = yv; video_on = vv;
    sbq.push_back(model_pixel(xv, yv, vv));
  endtask

  task automatic do_eval(input logic [9:0] ey, input bit retrig);
    int busy;
    busy = 0;
    model_eval(ey);
    step(10'(EVX), ey, 1'b0);
    for (int i = 1; i <= NOBJ + 3; i++) begin
      step((retrig && i == 2) ? 10'(EVX) : 10'(EVX + i), ey, 1'b0);
      if (eval_busy) busy++;
    end
    check_eq($sformatf("eval_busy_cycles_y%0d", ey), 32'(busy), 32'(NOBJ + 1));
    check_eq($sformatf("overflow_y%0d", ey), 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_line(input logic [9:0] ly, input int xlo, input int xhi);
    for (int xi = xlo; xi <= xhi; xi++) step(10'(xi), ly, 1'b1);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(10'd0, 10'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NOBJ; i++) oam_mem[i] = '0;
    rst_n = 1'b0; video_on = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_sprite_on", 32'(sprite_on), 32'd0);
    check_eq("rst_color", 32'(color), 32'd0);
    check_eq("rst_obj_id", 32'(obj_id), 32'd0);
    check_eq("rst_oam_addr", 32'(oam_addr), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_eval_busy", 32'(eval_busy), 32'd0);
    rst_n = 1'b1;

    // Single object at (100,100); disabled decoy at the same place
    oam_mem[0] = oam_word(1'b1, 100, 100, 2'd0, 3'd1, 3'd2);
    oam_mem[1] = oam_word(1'b0, 100, 100, 2'd0, 3'd2, 3'd3);
    do_eval(10'd98, 0);  do_line(10'd99, 95, 135);
    do_eval(10'd99, 0);  do_line(10'd100, 95, 135);
    do_eval(10'd100, 1); do_line(10'd101, 95, 135);
    do_eval(10'd130, 0); do_line(10'd131, 95, 135);
    do_eval(10'd131, 0); do_line(10'd132, 95, 135);

    // Priority between objects 2 and 5, then no fall-through on transparency
    for (int i = 0; i < NOBJ; i++) oam_mem[i] = '0;
    oam_mem[2] = oam_word(1'b1, 200, 50, 2'd2, 3'd3, 3'd4);
    oam_mem[5] = oam_word(1'b1, 216, 50, 2'd3, 3'd5, 3'd6);
    do_eval(10'd59, 0); do_line(10'd60, 195, 250);
    oam_mem[2] = oam_word(1'b1, 200, 50, 2'd2, 3'd7, 3'd4);
    do_eval(10'd59, 0); do_line(10'd60, 195, 250);

    // Six hits on one line, then a line with two hits
    for (int i = 0; i < 4; i++) oam_mem[i] = oam_word(1'b1, 300 + 40 * i, 300, 2'(i), 3'd2, 3'(i));
    for (int i = 4; i < 6; i++) oam_mem[i] = oam_word(1'b1, 300 + 40 * i, 280, 2'(i), 3'd4, 3'(i));
    do_eval(10'd304, 0); do_line(10'd305, 295, 540);
    do_eval(10'd289, 0); do_line(10'd290, 455, 540);

    // Vertical and horizontal wrap: last line targets line 0
    for (int i = 0; i < NOBJ; i++) oam_mem[i] = '0;
    oam_mem[0] = oam_word(1'b1, 1010, 1020, 2'd1, 3'd4, 3'd5);
    do_eval(10'(VL), 0); do_line(10'd0, 1000, 1023); do_line(10'd0, 0, 25);

    // Reset in the middle of a scan
    oam_mem[0] = oam_word(1'b1, 100, 100, 2'd0, 3'd1, 3'd2);
    do_eval(10'd100, 0); do_line(10'd101, 98, 110);
    flush();
    model_eval(10'd100);
    for (int i = 0; i < 4; i++) step(10'(EVX + i), 10'd100, 1'b0);
    check_eq("busy_before_reset", 32'(eval_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_sprite_on", 32'(sprite_on), 32'd0);
    check_eq("midrst_color", 32'(color), 32'd0);
    check_eq("midrst_obj_id", 32'(obj_id), 32'd0);
    check_eq("midrst_eval_busy", 32'(eval_busy), 32'd0);
    check_eq("midrst_oam_addr", 32'(oam_addr), 32'd0);
    check_eq("midrst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    m_cnt = 0; m_ovf = 0;
    do_line(10'd101, 95, 135);

    // ROM address offsets for dir=1 at row 0, column 5
    oam_mem[0] = oam_word(1'b1, 100, 100, 2'd1, 3'd1, 3'd2);
    do_eval(10'd99, 0);
    step(10'd105, 10'd100, 1'b1);
    @(posedge clk); #1;
`ifdef SPRITE_ENGINE_ROTATE_EN
    check_eq("rom_addr_dir1", 32'(rom_addr), 32'({3'd1, 3'd2, 2'b00, 5'd5, 5'd31}));
`else
    check_eq("rom_addr_dir1", 32'(rom_addr), 32'({3'd1, 3'd2, 2'b01, 5'd0, 5'd5}));
`endif
    do_line(10'd100, 96, 140);
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
